// File: rtl/jk_cmd_if.sv
// Command channel into the JK drive sequencer.
// A valid/ready handshake carrying a 2-bit opcode and a repeat count.
// The producer (master) offers commands; the sequencer (slave) accepts them.
interface jk_cmd_if #(
    parameter int REP_W = 4
);
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [REP_W-1:0] cmd_rep;
    logic             cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rep,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rep,
        output cmd_ready
    );
endinterface

// File: rtl/jk_drive_sequencer.sv
// JK drive sequencer.
// Buffers opcode commands in a small FIFO and replays each one on registered
// j/k outputs for cmd_rep+1 cycles. Consecutive commands follow each other
// with no idle cycle between them.
// Optional feature macro: JK_SEQ_CHECK_EN. When defined, a model of the
// downstream JK flop is built and any divergence from the fed-back q sets a
// sticky mismatch flag. When undefined, q_fb is ignored and q_exp/mismatch
// are tied low.
module jk_drive_sequencer #(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    jk_cmd_if.slave                  cmd,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    input  logic                     q_fb,
    output logic                     q_exp,
    output logic                     mismatch
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = REP_W + 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    // Map an opcode onto the {j,k} pair driven towards the flop.
    function automatic logic [1:0] op_to_jk(input logic [1:0] op);
        logic [1:0] jk;
        case (op)
            2'b00:   jk = 2'b00;   // HOLD
            2'b01:   jk = 2'b01;   // RESET: j=0, k=1
            2'b10:   jk = 2'b10;   // SET:   j=1, k=0
            2'b11:   jk = 2'b11;   // TOGGLE
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

    // Next state of a JK flop given its present state and inputs.
    function automatic logic jk_next(input logic q, input logic jin, input logic kin);
        logic qn;
        case ({jin, kin})
            2'b00:   qn = q;
            2'b01:   qn = 1'b0;
            2'b10:   qn = 1'b1;
            2'b11:   qn = ~q;
            default: qn = q;
        endcase
        return qn;
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              ready_r;
    logic              busy_r;

    // Sequencer state
    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [REP_W-1:0]  rep_cnt_r;
    logic              j_r;
    logic              k_r;

    // Handshake / pop decisions
    logic              push_s;
    logic              pop_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] head_s;
    logic [1:0]        head_op_s;
    logic [REP_W-1:0]  head_rep_s;

    assign push_s       = cmd.cmd_valid & ready_r;
    assign fifo_empty_s = (cnt_r == CNT_ZERO);
    assign head_s       = mem_r[rd_ptr_r];
    assign head_op_s    = head_s[DATA_W-1:REP_W];
    assign head_rep_s   = head_s[REP_W-1:0];

    // Decide whether the head entry is consumed this cycle and where the FSM goes.
    always_comb begin
        pop_s       = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    pop_s       = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rep_cnt_r != REP_ZERO) begin
                    pop_s       = 1'b0;
                    state_nxt_s = ST_ISSUE;
                end else if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    pop_s       = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                pop_s       = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
            2'b11:   cnt_nxt_s = cnt_r;
            2'b00:   cnt_nxt_s = cnt_r;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // FIFO payload write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd.cmd_op, cmd.cmd_rep};
        end
    end

    // FIFO pointers, occupancy, and the registered ready/busy flags derived from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= CNT_ZERO;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r   <= cnt_nxt_s;
            ready_r <= (cnt_nxt_s != CNT_FULL);
            busy_r  <= (state_nxt_s == ST_ISSUE) || (cnt_nxt_s != CNT_ZERO);
        end
    end

    // Replay engine: load j/k on pop, hold them while the repeat count runs down,
    // and return to 00 when no further command is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rep_cnt_r <= REP_ZERO;
            j_r       <= 1'b0;
            k_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (pop_s) begin
                {j_r, k_r} <= op_to_jk(head_op_s);
                rep_cnt_r  <= head_rep_s;
            end else if ((state_r == ST_ISSUE) && (rep_cnt_r != REP_ZERO)) begin
                rep_cnt_r <= rep_cnt_r - REP_ONE;
            end else begin
                j_r       <= 1'b0;
                k_r       <= 1'b0;
                rep_cnt_r <= REP_ZERO;
            end
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic q_exp_r;
    logic mismatch_r;

    // Shadow the downstream flop and latch any disagreement until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_exp_r    <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            q_exp_r <= jk_next(q_exp_r, j_r, k_r);
            if (q_fb != q_exp_r) begin
                mismatch_r <= 1'b1;
            end else begin
                mismatch_r <= mismatch_r;
            end
        end
    end

    assign q_exp    = q_exp_r;
    assign mismatch = mismatch_r;
`else
    logic unused_q_fb_s;

    assign unused_q_fb_s = q_fb;
    assign q_exp         = 1'b0;
    assign mismatch      = 1'b0;
`endif

    assign cmd.cmd_ready = ready_r;
    assign j             = j_r;
    assign k             = k_r;
    assign busy          = busy_r;
    assign fifo_cnt      = cnt_r;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Directed bench for jk_drive_sequencer with a live JK flop model on q_fb.
// Expected values are hand-derived; q_exp/mismatch expectations follow
// whether JK_SEQ_CHECK_EN is defined for the build.
module tb_jk_drive_sequencer;

`ifdef JK_SEQ_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       j;
    logic       k;
    logic       busy;
    logic [2:0] fifo_cnt;
    logic       q_fb;
    logic       q_exp;
    logic       mismatch;
    logic       q_flop;
    logic       force_q;

    int n_cmp;
    int n_bad;

    jk_cmd_if #(.REP_W(4)) cmd_bus ();

    jk_drive_sequencer #(.DEPTH(4), .REP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_bus),
        .j        (j),
        .k        (k),
        .busy     (busy),
        .fifo_cnt (fifo_cnt),
        .q_fb     (q_fb),
        .q_exp    (q_exp),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream JK flop sharing the sequencer's reset.
    always @(posedge clk) begin
        if (rst) begin
            q_flop <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_flop <= 1'b0;
                2'b10:   q_flop <= 1'b1;
                2'b11:   q_flop <= ~q_flop;
                default: q_flop <= q_flop;
            endcase
        end
    end

    assign q_fb = force_q ? 1'b1 : q_flop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ops [3];
        logic [3:0] reps [3];
        logic [1:0] exp_jk [5];
        logic       exp_q [5];
        int pushed, set_cyc, tog_cyc, max_cnt;
        logic saw_full, done;

        n_cmp = 0;
        n_bad = 0;
        force_q = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'b00;
        cmd_bus.cmd_rep   = 4'd0;

        // 1: reset state
        rst = 1'b1;
        step();
        step();
        check("rst_j", 32'(j), 32'd0);
        check("rst_k", 32'(k), 32'd0);
        check("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_qexp", 32'(q_exp), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        rst = 1'b0;
        step();

        // 2: SET rep=2 -> 10 for three cycles starting one edge after accept
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = 2'b10;
        cmd_bus.cmd_rep   = 4'd2;
        step();
        cmd_bus.cmd_valid = 1'b0;
        check("t2_accept_jk", 32'({j, k}), 32'd0);
        check("t2_accept_cnt", 32'(fifo_cnt), 32'd1);
        check("t2_accept_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t2_set_jk", 32'({j, k}), 32'({2'b10}));
        end
        step();
        check("t2_end_jk", 32'({j, k}), 32'd0);
        check("t2_end_busy", 32'(busy), 32'd0);
        check("t2_qexp", 32'(q_exp), 32'(CHK));

        // 3: overfill while a long SET is replaying
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = 2'b10;
        cmd_bus.cmd_rep   = 4'd15;
        step();
        cmd_bus.cmd_op  = 2'b11;
        cmd_bus.cmd_rep = 4'd0;
        pushed = 0; set_cyc = 0; tog_cyc = 0; max_cnt = 0;
        saw_full = 1'b0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) pushed++;
            step();
            if (pushed == 5) cmd_bus.cmd_valid = 1'b0;
            if (fifo_cnt == 3'd4 && !cmd_bus.cmd_ready) saw_full = 1'b1;
            if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
            if (j && !k) set_cyc++;
            if (j && k) tog_cyc++;
            if (pushed == 5 && !busy) done = 1'b1;
        end
        check("t3_done", 32'(done), 32'd1);
        check("t3_full_seen", 32'(saw_full), 32'd1);
        check("t3_max_cnt", 32'(max_cnt), 32'd4);
        check("t3_pushed", 32'(pushed), 32'd5);
        check("t3_set_cycles", 32'(set_cyc), 32'd16);
        check("t3_toggle_cycles", 32'(tog_cyc), 32'd5);
        check("t3_qexp", 32'(q_exp), 32'd0);
        check("t3_mismatch", 32'(mismatch), 32'd0);

        // 4: back-to-back SET/0, TOGGLE/1, RESET/0
        ops[0] = 2'b10; reps[0] = 4'd0;
        ops[1] = 2'b11; reps[1] = 4'd1;
        ops[2] = 2'b01; reps[2] = 4'd0;
        exp_jk[0] = 2'b10; exp_jk[1] = 2'b11; exp_jk[2] = 2'b11;
        exp_jk[3] = 2'b01; exp_jk[4] = 2'b00;
        exp_q[0] = 1'b0; exp_q[1] = 1'b1; exp_q[2] = 1'b0;
        exp_q[3] = 1'b1; exp_q[4] = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            if (i < 3) begin
                cmd_bus.cmd_valid = 1'b1;
                cmd_bus.cmd_op    = ops[i];
                cmd_bus.cmd_rep   = reps[i];
            end else begin
                cmd_bus.cmd_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                check($sformatf("t4_jk%0d", i - 1), 32'({j, k}), 32'(exp_jk[i-1]));
                check($sformatf("t4_qexp%0d", i - 1), 32'(q_exp), 32'(exp_q[i-1] & CHK));
            end
        end
        check("t4_mismatch", 32'(mismatch), 32'd0);

        // 5: one edge of forced q_fb=1 against q_exp=0
        force_q = 1'b1;
        step();
        force_q = 1'b0;
        check("t5_mismatch_set", 32'(mismatch), 32'(CHK));
        step();
        step();
        step();
        check("t5_mismatch_sticky", 32'(mismatch), 32'(CHK));

        // 6: reset mid-replay with three commands queued
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = 2'b10;
        cmd_bus.cmd_rep   = 4'd7;
        step();
        cmd_bus.cmd_op  = 2'b11;
        cmd_bus.cmd_rep = 4'd0;
        step();
        step();
        step();
        cmd_bus.cmd_valid = 1'b0;
        check("t6_pre_cnt", 32'(fifo_cnt), 32'd3);
        check("t6_pre_jk", 32'({j, k}), 32'({2'b10}));
        rst = 1'b1;
        step();
        check("t6_rst_jk", 32'({j, k}), 32'd0);
        check("t6_rst_cnt", 32'(fifo_cnt), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        check("t6_rst_mismatch", 32'(mismatch), 32'd0);
        check("t6_rst_qexp", 32'(q_exp), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_post_jk", 32'({j, k}), 32'd0);
            check("t6_post_cnt", 32'(fifo_cnt), 32'd0);
        end
        check("t6_post_busy", 32'(busy), 32'd0);
        check("t6_post_mismatch", 32'(mismatch), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
